// File: rtl/wb_trace_monitor.sv
// wb_trace_monitor: writeback trace FIFO with cycle/retire/drop counters and a cycle-limited capture window
module wb_trace_monitor #(
  parameter int XLEN        = 32,
  parameter int RADDR_W     = 5,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic [XLEN-1:0]    wb_pc,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [RADDR_W-1:0] rd_rd,
  output logic [XLEN-1:0]    rd_data,
  output logic [XLEN-1:0]    rd_pc,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retire_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               full,
  output logic               empty,
  output logic               done,
  output logic               overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
  logic [RADDR_W+2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] occ;
  logic cap, pop, push, drop, tick;
  assign tick = enable && !done;
  assign cap = wb_valid && wb_rd != '0 && tick;
  assign pop = rd_valid && rd_ready;
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;
  assign full = occ == DEP;
  assign empty = occ == '0;
  assign rd_valid = !empty;
  assign {rd_rd, rd_data, rd_pc} = mem[head];
  always_ff @(posedge clk)
    if (push && reset) mem[tail] <= {wb_rd, wb_data, wb_pc};
  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ <= '0;
      cycle_count <= '0;
      retire_count <= '0;
      drop_count <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      if (tick && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (tick && CYCLE_LIMIT != 0 && cycle_count != '1 && cycle_count + 1'b1 == CNT_W'(CYCLE_LIMIT)) done <= 1'b1;
      if (cap && retire_count != '1) retire_count <= retire_count + 1'b1;
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_trace_monitor.sv
// tb_wb_trace_monitor: scoreboard bench for wb_trace_monitor (DEPTH=4, CYCLE_LIMIT=15)
module tb_wb_trace_monitor;
  localparam int XLEN = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W = 32;
  typedef logic [RADDR_W+2*XLEN-1:0] entry_t;
  logic clk = 0;
  logic reset, enable, wb_valid, rd_ready, rd_valid, full, empty, done, overflow;
  logic [RADDR_W-1:0] wb_rd, rd_rd;
  logic [XLEN-1:0] wb_data, wb_pc, rd_data, rd_pc;
  logic [CNT_W-1:0] cycle_count, retire_count, drop_count;
  int tests = 0;
  int fails = 0;
  entry_t exp_q[$];
  wb_trace_monitor #(.XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(4), .CNT_W(CNT_W), .CYCLE_LIMIT(15)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_rd(rd_rd), .rd_data(rd_data), .rd_pc(rd_pc), .cycle_count(cycle_count),
    .retire_count(retire_count), .drop_count(drop_count), .full(full), .empty(empty),
    .done(done), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (reset && rd_valid && rd_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got rd=%0d data=%0h pc=%0h, want no entry", rd_rd, rd_data, rd_pc);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        if ({rd_rd, rd_data, rd_pc} !== e) begin
          fails++;
          $display("FAIL pop_entry: got rd=%0d data=%0h pc=%0h, want rd=%0d data=%0h pc=%0h",
                   rd_rd, rd_data, rd_pc, e[2*XLEN+:RADDR_W], e[XLEN+:XLEN], e[XLEN-1:0]);
        end
      end
    end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic wb(input logic [RADDR_W-1:0] r, input logic [XLEN-1:0] d, input logic [XLEN-1:0] p, input bit expect_it);
    wb_valid = 1;
    wb_rd = r;
    wb_data = d;
    wb_pc = p;
    if (expect_it) exp_q.push_back({r, d, p});
  endtask
  task automatic do_reset;
    reset = 0;
    enable = 1;
    wb_valid = 0;
    rd_ready = 0;
    step;
    exp_q.delete();
    chk("rst_cycle", cycle_count, 0);
    chk("rst_retire", retire_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1;
  endtask
  task automatic drain(input string n);
    int k;
    rd_ready = 1;
    for (k = 0; k < 10 && !empty; k++) step;
    rd_ready = 0;
    chk({n, "_empty"}, empty, 1);
    chk({n, "_left"}, exp_q.size(), 0);
  endtask
  initial begin
    reset = 0; enable = 0; wb_valid = 0; rd_ready = 0; wb_rd = 0; wb_data = 0; wb_pc = 0;
    #1;
    do_reset;
    repeat (14) step;
    chk("lim_cycle14", cycle_count, 14);
    chk("lim_done14", done, 0);
    step;
    chk("lim_cycle15", cycle_count, 15);
    chk("lim_done15", done, 1);
    wb(3, 32'h33, 32'h40, 0);
    repeat (3) step;
    wb_valid = 0;
    chk("lim_hold", cycle_count, 15);
    chk("lim_retire", retire_count, 0);
    chk("lim_empty", empty, 1);
    chk("lim_done_sticky", done, 1);
    do_reset;
    wb(1, 7, 32'h100, 1); step;
    wb(0, 5, 32'h104, 0); step;
    wb(4, 7, 32'h108, 1); step;
    wb_valid = 0;
    chk("x0_retire", retire_count, 2);
    chk("x0_rd_valid", rd_valid, 1);
    drain("x0");
    do_reset;
    for (int i = 0; i < 6; i++) begin
      wb(5'(i + 1), 32'h10 + i, 32'h200 + 4 * i, i < 4);
      step;
    end
    wb_valid = 0;
    chk("ovf_full", full, 1);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_retire", retire_count, 6);
    wb(9, 32'h99, 32'h300, 1);
    rd_ready = 1;
    step;
    wb_valid = 0;
    rd_ready = 0;
    chk("pp_full", full, 1);
    chk("pp_drop", drop_count, 2);
    chk("pp_retire", retire_count, 7);
    drain("pp");
    do_reset;
    wb(2, 32'h22, 32'h400, 1); step;
    enable = 0;
    wb(3, 32'h33, 32'h404, 0);
    repeat (3) step;
    chk("en_cycle", cycle_count, 1);
    chk("en_retire", retire_count, 1);
    enable = 1;
    wb(5, 32'h55, 32'h408, 1); step;
    wb_valid = 0;
    chk("en_retire2", retire_count, 2);
    chk("en_cycle2", cycle_count, 2);
    drain("en");
    wb(6, 32'h66, 32'h40c, 0); step;
    wb(7, 32'h77, 32'h410, 0);
    reset = 0;
    step;
    wb_valid = 0;
    exp_q.delete();
    chk("mid_cycle", cycle_count, 0);
    chk("mid_retire", retire_count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_done", done, 0);
    chk("mid_overflow", overflow, 0);
    reset = 1;
    step;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
